// File: rtl/neuron_lane_array.sv
// neuron_lane_array: NUM_LANES fixed-point dot-product neurons sharing one
// activation stream, each with its own weight stream and bias. Results are
// rounded/truncated, passed through ReLU or saturating linear activation and
// held under back-pressure until the downstream handshake.
// Optional build macro: ROUND_NEAREST_EN (round half up instead of floor).
module neuron_lane_array #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 15,
    parameter int ACC_W      = 48,
    parameter int NUM_LANES  = 4,
    parameter int NUM_INPUTS = 784
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        act_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    data_in,
    input  logic [NUM_LANES*DATA_W-1:0] weight_in,
    input  logic [NUM_LANES*DATA_W-1:0] bias_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic                        busy
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);

    // Output range of one DATA_W word, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] acc [NUM_LANES];

    logic                      beat;
    logic                      final_beat;
    logic signed [ACC_W-1:0]   prod_ext_p0 [NUM_LANES];
    logic signed [ACC_W-1:0]   sum_p0      [NUM_LANES];
    logic        [DATA_W-1:0]  res_p0      [NUM_LANES];

    // Drop the fraction bits; with rounding enabled, add half an LSB first.
    // Guard bits in ACC_W keep the rounding add from overflowing.
    function automatic logic signed [ACC_W-1:0] scale_sum(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] t;
        t = s;
`ifdef ROUND_NEAREST_EN
        t = t + (ACC_W'(1) << (FRAC_W - 1));
`endif
        return t >>> FRAC_W;
    endfunction

    // ReLU clamps negatives to zero; both modes saturate to the DATA_W range.
    function automatic logic [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] v,
                                                   input logic relu);
        if (relu && v[ACC_W-1]) return '0;
        if (v > MAX_V)          return MAX_V[DATA_W-1:0];
        if (v < MIN_V)          return MIN_V[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == HOLD);
    assign busy       = (count != '0) || out_valid;
    // An abort wins over any beat presented in the same cycle.
    assign beat       = in_valid && in_ready && !clr;
    assign final_beat = beat && (count == LAST_BEAT);

    // Per-lane product, running sum with bias, and activated result.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            logic signed [2*DATA_W-1:0] a_ext;
            logic signed [2*DATA_W-1:0] w_ext;
            logic signed [2*DATA_W-1:0] prod;
            logic        [DATA_W-1:0]   w_raw;
            logic        [DATA_W-1:0]   b_raw;
            logic signed [ACC_W-1:0]    bias_sh;
            w_raw   = weight_in[k*DATA_W +: DATA_W];
            b_raw   = bias_in[k*DATA_W +: DATA_W];
            a_ext   = $signed({{DATA_W{data_in[DATA_W-1]}}, data_in});
            w_ext   = $signed({{DATA_W{w_raw[DATA_W-1]}}, w_raw});
            prod    = a_ext * w_ext;
            prod_ext_p0[k] = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
            bias_sh = $signed({{(ACC_W-DATA_W){b_raw[DATA_W-1]}}, b_raw}) <<< FRAC_W;
            sum_p0[k] = acc[k] + prod_ext_p0[k] + bias_sh;
            res_p0[k] = activate(scale_sum(sum_p0[k]), act_sel);
        end
    end

    // Next-state logic: abort returns to ACCUM, final beat enters HOLD,
    // downstream handshake releases HOLD.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (final_beat) state_next = HOLD;
                HOLD:    if (out_ready)  state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // Beat counter: wraps to zero on the final beat or an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      count <= '0;
        else if (clr || final_beat)   count <= '0;
        else if (beat)                count <= count + CNT_W'(1);
    end

    // Per-lane accumulators; final result registered into data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) acc[k] <= '0;
            data_out <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (clr || final_beat) acc[k] <= '0;
                else if (beat)         acc[k] <= acc[k] + prod_ext_p0[k];
                if (final_beat) data_out[k*DATA_W +: DATA_W] <= res_p0[k];
            end
        end
    end

endmodule

// File: doc/neuron_lane_array.md
Name: neuron_lane_array

Overview:
Parametrised successor to the single fixed-point neuron. It computes NUM_LANES dot products in parallel over one shared input stream, with one weight stream per lane. Width, fraction bits and accumulator width are configurable, and the activation (ReLU or saturating linear) is selected at runtime. It adds valid/ready handshaking on both sides, result holding under back-pressure and a synchronous abort, so it can sit between the pixel/activation buffer and the next layer's input FIFO.

Parameters:
- DATA_W, 16: width of data, weight, bias and output words, all signed two's complement.
- FRAC_W, 15: fraction bits of every DATA_W word (default Q1.15).
- ACC_W, 48: signed accumulator width. Must be ≥ 2*DATA_W + clog2(NUM_INPUTS) + 1.
- NUM_LANES, 4: parallel neurons sharing data_in.
- NUM_INPUTS, 784: beats per dot product. Must be ≥ 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous abort. Drops the partial sum and any held result.
- act_sel, input, 1: 0 = saturating linear, 1 = ReLU. Sampled on the final beat.
- in_valid, input, 1: data_in/weight_in beat valid.
- in_ready, output, 1: block can accept a beat.
- data_in, input, DATA_W: activation broadcast to all lanes.
- weight_in, input, NUM_LANES*DATA_W: lane k weight at bits [k*DATA_W +: DATA_W].
- bias_in, input, NUM_LANES*DATA_W: per-lane bias, same packing. Sampled on the final beat.
- out_valid, output, 1: data_out holds a result.
- out_ready, input, 1: downstream accepts the result.
- data_out, output, NUM_LANES*DATA_W: per-lane activations, same packing.
- busy, output, 1: high when count ≠ 0 or out_valid is high.

Behaviour:
- Reset (async, rst=1): state=ACCUM, count=0, all accumulators=0, out_valid=0, data_out=0, in_ready=1 after release.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Beat accepted when in_valid & in_ready.
- Per accepted beat, each lane computes product = signed(data_in)*signed(weight lane). The product is 2*DATA_W bits with 2*FRAC_W fraction bits and is sign-extended into ACC_W.
- Beats 0..NUM_INPUTS-2: acc += product; count += 1.
- Final beat (count == NUM_INPUTS-1):
  - sum = acc + product + (sign-extended bias << FRAC_W).
  - Result is sum >>> FRAC_W (arithmetic), then activation.
  - Linear: saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU: negative → 0, else saturate to 2^(DATA_W-1)-1.
  - data_out registered on that clock edge; out_valid=1 the next cycle (latency 1 cycle from the final beat).
  - acc=0, count=0, state → HOLD.
- HOLD: data_out is stable until out_valid & out_ready, then state → ACCUM, out_valid=0.
  - in_ready becomes 1 in the cycle after the handshake; there is no combinational ready path.
- data_out keeps its last value after the handshake; only out_valid qualifies it.
- clr=1 (any state, priority over beats and handshake): acc=0, count=0, out_valid=0, state → ACCUM, data_out unchanged. Any beat presented in the same cycle is dropped.
- in_valid low mid-vector: accumulation pauses; count and acc are held indefinitely.
- NUM_INPUTS=1: every beat is a final beat.
- Async rst mid-vector or in HOLD: immediate return to the reset values; the partial result is lost.
- No debug $display in synthesisable code.

Optional Feature:
ROUND_NEAREST_EN
- Defined: before the shift, add 2^(FRAC_W-1) to sum (round half up), then shift and saturate. The add cannot overflow because ACC_W carries guard bits.
- Undefined: truncation (floor via arithmetic shift), as in the base neuron.

Test Plan (NUM_LANES=2, NUM_INPUTS=4, defaults otherwise):
- T1, basic MAC: 4 beats, data=0x2000, w0=0x4000, w1=0xC000, bias0=0x1000, bias1=0x0000, act_sel=1 → lane0=0x5000 (0.625), lane1=0x0000 (ReLU).
- T2, linear and saturation: same as T1 with act_sel=0 → lane1=0xC000. Then data=0x7FFF, w0=0x7FFF, 4 beats → lane0=0x7FFF; w0=0x8001 → lane0=0x8000.
- T3, back-pressure: out_ready=0 for 10 cycles after out_valid → data_out stable, in_ready=0, in_valid beats ignored and count unchanged. Raise out_ready → out_valid drops, in_ready=1 the next cycle, and the next vector computes correctly.
- T4, bubbles: in_valid toggled 1,0,0,1,1,0,1 carrying T1 data → same result as T1; out_valid exactly 1 cycle after the 4th accepted beat.
- T5, abort/reset: clr after 2 beats, then a full T1 vector → 0x5000 (no residue). Assert rst asynchronously in HOLD → out_valid=0, data_out=0 without waiting for a clock edge.
- T6, rounding: one beat data=0x0001, w0=0x4000, then three zero beats, bias=0 → lane0=0x0000 without ROUND_NEAREST_EN, 0x0001 with it.
